pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 32 +++
 rtl/pipe_hazard_ctrl_stat_counter.sv | 27 ++
 rtl/pipe_hazard_ctrl.sv | 102 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM encoding, counter width and the load-use detect helper.
package pipe_hazard_ctrl_pkg;

   localparam int CNT_W = 32;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HALT   = 2'd1,
      ST_RESUME = 2'd2
   } state_e;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic ifid_clr;
      logic idex_clr;
   } ctrl_t;

   // Register 0 is hardwired zero, so a load to it never creates a dependency.
   function automatic logic load_use(input logic       ex_memread,
                                     input logic [4:0] ex_rd,
                                     input logic       use_rs,
                                     input logic [4:0] rs,
                                     input logic       use_rt,
                                     input logic [4:0] rt);
      return ex_memread && (ex_rd != 5'd0) &&
             ((use_rs && (rs == ex_rd)) || (use_rt && (rt == ex_rd)));
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_stat_counter.sv
// Free-running statistics counter: synchronous clear, increment enable,
// wraps at all-ones.
module stat_counter
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (inc) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (clr) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush/halt controller with RUN/HALT/RESUME FSM and
// cycle, stall and flush statistics.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic             in_CLK,
   input  logic             in_CLR,
   input  logic [4:0]       in_id_rs,
   input  logic [4:0]       in_id_rt,
   input  logic             in_id_use_rs,
   input  logic             in_id_use_rt,
   input  logic             in_ex_memread,
   input  logic [4:0]       in_ex_rd,
   input  logic             in_ex_branch_taken,
   input  logic             in_ex_halt,
   input  logic             in_go,
   output logic             out_pc_EN,
   output logic             out_ifid_EN,
   output logic             out_idex_EN,
   output logic             out_ifid_CLR,
   output logic             out_idex_CLR,
   output logic             out_halted,
   output logic [CNT_W-1:0] out_cycle_cnt,
   output logic [CNT_W-1:0] out_stall_cnt,
   output logic [CNT_W-1:0] out_flush_cnt
);

   state_e state_d, state_q;
   ctrl_t  ctrl;
   logic   hazard, stall, flush, halted;

   assign hazard = load_use(in_ex_memread, in_ex_rd, in_id_use_rs, in_id_rs,
                            in_id_use_rt, in_id_rt);

   always_comb begin
      state_d = state_q;
      ctrl    = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                  ifid_clr: 1'b0, idex_clr: 1'b0};
      stall   = 1'b0;
      flush   = 1'b0;
      halted  = 1'b0;
      if (in_CLR) begin
         state_d = ST_RUN;
         ctrl    = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0,
                     ifid_clr: 1'b1, idex_clr: 1'b1};
      end else if (state_q == ST_HALT) begin
         ctrl   = '0;
         halted = 1'b1;
         if (in_go) state_d = ST_RESUME;
      end else if ((state_q == ST_RUN) && in_ex_halt) begin
         ctrl    = '0;
         state_d = ST_HALT;
      end else begin
         // RESUME lets the halt instruction leave EX; any stray encoding recovers to RUN.
         state_d = ST_RUN;
         if (in_ex_branch_taken) begin
            flush         = 1'b1;
            ctrl.ifid_clr = 1'b1;
            ctrl.idex_clr = 1'b1;
         end else if (hazard) begin
            stall         = 1'b1;
            ctrl.pc_en    = 1'b0;
            ctrl.ifid_en  = 1'b0;
            ctrl.idex_clr = 1'b1;
         end
      end
   end

   always_ff @(posedge in_CLK) begin
      if (in_CLR) state_q <= ST_RUN;
      else        state_q <= state_d;
   end

   assign out_pc_EN    = ctrl.pc_en;
   assign out_ifid_EN  = ctrl.ifid_en;
   assign out_idex_EN  = ctrl.idex_en;
   assign out_ifid_CLR = ctrl.ifid_clr;
   assign out_idex_CLR = ctrl.idex_clr;
   assign out_halted   = halted;

   stat_counter u_cycle_cnt (
      .clk (in_CLK),
      .clr (in_CLR),
      .inc (state_q != ST_HALT),
      .cnt (out_cycle_cnt)
   );

   stat_counter u_stall_cnt (
      .clk (in_CLK),
      .clr (in_CLR),
      .inc (stall),
      .cnt (out_stall_cnt)
   );

   stat_counter u_flush_cnt (
      .clk (in_CLK),
      .clr (in_CLR),
      .inc (flush),
      .cnt (out_flush_cnt)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected values are queued as each
// step is driven and popped when the DUT output is sampled.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        clr;
   logic [4:0]  id_rs, id_rt, ex_rd;
   logic        use_rs, use_rt, memread, br, halt, go;
   logic        pc_en, ifid_en, idex_en, ifid_clr, idex_clr, halted;
   logic [31:0] cyc_cnt, stl_cnt, fls_cnt;

   logic [31:0] e_cyc, e_stl, e_fls;
   string       tag_q[$];
   logic [31:0] exp_q[$];
   int          n_chk  = 0;
   int          n_fail = 0;

   // {pc_EN, ifid_EN, idex_EN, ifid_CLR, idex_CLR, halted}
   localparam logic [5:0] C_RUN    = 6'b111000;
   localparam logic [5:0] C_STALL  = 6'b001010;
   localparam logic [5:0] C_FLUSH  = 6'b111110;
   localparam logic [5:0] C_FREEZE = 6'b000000;
   localparam logic [5:0] C_HALTED = 6'b000001;
   localparam logic [5:0] C_RESET  = 6'b000110;

   pipe_hazard_ctrl dut (
      .in_CLK             (clk),
      .in_CLR             (clr),
      .in_id_rs           (id_rs),
      .in_id_rt           (id_rt),
      .in_id_use_rs       (use_rs),
      .in_id_use_rt       (use_rt),
      .in_ex_memread      (memread),
      .in_ex_rd           (ex_rd),
      .in_ex_branch_taken (br),
      .in_ex_halt         (halt),
      .in_go              (go),
      .out_pc_EN          (pc_en),
      .out_ifid_EN        (ifid_en),
      .out_idex_EN        (idex_en),
      .out_ifid_CLR       (ifid_clr),
      .out_idex_CLR       (idex_clr),
      .out_halted         (halted),
      .out_cycle_cnt      (cyc_cnt),
      .out_stall_cnt      (stl_cnt),
      .out_flush_cnt      (fls_cnt)
   );

   always #5 clk = ~clk;

   task automatic push(input string tag, input logic [31:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      string       tag;
      logic [31:0] exp;
      tag = tag_q.pop_front();
      exp = exp_q.pop_front();
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic c, input logic mr, input logic [4:0] rd,
                         input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt,
                         input logic b, input logic h, input logic g);
      clr = c; memread = mr; ex_rd = rd; id_rs = rs; use_rs = urs;
      id_rt = rt; use_rt = urt; br = b; halt = h; go = g;
   endtask

   // Inputs are already applied; check outputs this cycle, then counters after the edge.
   task automatic step(input string tag, input logic [5:0] exp_ctrl,
                       input logic exp_stall, input logic exp_flush);
      #1;
      push({tag, ".ctrl"}, {26'd0, exp_ctrl});
      pop_chk({26'd0, pc_en, ifid_en, idex_en, ifid_clr, idex_clr, halted});
      if (clr) begin
         e_cyc = 0; e_stl = 0; e_fls = 0;
      end else begin
         if (!exp_ctrl[0]) e_cyc = e_cyc + 1;
         if (exp_stall)    e_stl = e_stl + 1;
         if (exp_flush)    e_fls = e_fls + 1;
      end
      push({tag, ".cycle"}, e_cyc);
      push({tag, ".stall"}, e_stl);
      push({tag, ".flush"}, e_fls);
      @(posedge clk);
      #1;
      pop_chk(cyc_cnt);
      pop_chk(stl_cnt);
      pop_chk(fls_cnt);
      @(negedge clk);
   endtask

   initial begin
      e_cyc = 0; e_stl = 0; e_fls = 0;
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("reset", C_RESET, 0, 0);

      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("idle", C_RUN, 0, 0);
      set_in(0, 1, 5, 5, 1, 0, 0, 0, 0, 0);
      step("loaduse_rs", C_STALL, 1, 0);
      set_in(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      step("rd_zero", C_RUN, 0, 0);
      set_in(0, 1, 5, 5, 0, 0, 0, 0, 0, 0);
      step("rs_unused", C_RUN, 0, 0);
      set_in(0, 1, 7, 0, 1, 7, 1, 0, 0, 0);
      step("loaduse_rt", C_STALL, 1, 0);
      set_in(0, 0, 5, 5, 1, 0, 0, 0, 0, 0);
      step("no_memread", C_RUN, 0, 0);
      set_in(0, 1, 5, 5, 1, 0, 0, 1, 0, 0);
      step("branch_and_stall", C_FLUSH, 0, 1);
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      step("branch", C_FLUSH, 0, 1);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step("go_in_run", C_RUN, 0, 0);

      // Halt beats a simultaneous branch and load-use stall.
      set_in(0, 1, 5, 5, 1, 0, 0, 1, 1, 0);
      step("halt_freeze", C_FREEZE, 0, 0);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step("halted_1", C_HALTED, 0, 0);
      step("halted_2", C_HALTED, 0, 0);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      step("halted_go", C_HALTED, 0, 0);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step("resume", C_RUN, 0, 0);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("run_after_resume", C_RUN, 0, 0);

      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step("halt2_freeze", C_FREEZE, 0, 0);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("halt2_held", C_HALTED, 0, 0);
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("reset_in_halt", C_RESET, 0, 0);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("run_after_reset", C_RUN, 0, 0);

      force dut.u_cycle_cnt.cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.u_cycle_cnt.cnt_q;
      e_cyc = 32'hFFFF_FFFF;
      push("wrap.preload", 32'hFFFF_FFFF);
      pop_chk(cyc_cnt);
      step("wrap", C_RUN, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
